// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline stages.
//   state_t : MEM-stage access FSM states (IDLE, REQ, DONE)
//   SZ_*    : access size codes carried on size_in (2'b11 behaves as word)
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus with a req/ack handshake.
//   mem_req   : request, held until ack or abort
//   mem_we    : write enable
//   mem_addr  : word-aligned byte address
//   mem_be    : byte enables (little-endian lanes)
//   mem_wdata : lane-replicated store data
//   mem_rdata : read data, valid with mem_ack
//   mem_ack   : single-cycle completion pulse
// master = MEM stage, slave = memory.
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_align.sv
// Combinational lane logic for the MEM stage.
//   addr_lo     : effective address bits [1:0]
//   size        : SZ_BYTE / SZ_HALF / SZ_WORD (11 = word)
//   is_unsigned : zero-extend loads instead of sign-extend
//   wd          : raw store data (rt)
//   rdata       : raw memory read word
//   be          : byte enables for the access
//   wdata       : store data replicated across lanes
//   load_data   : selected and extended load value
//   misaligned  : half on odd address or word not on a 4-byte boundary
module mem_align
  import mips_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wd,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = rdata[{addr_lo, 3'b000} +: 8];
    half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    be         = 4'b1111;
    wdata      = wd;
    load_data  = rdata;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{wd[7:0]}};
        load_data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{wd[15:0]}};
        load_data  = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline.
//   clk, rst         : pipeline clock, async active-low reset
//   *_in / *In       : EX/MEM register fields (AluResIn is the address)
//   *_out / *Out     : MEM/WB register fields; pass-throughs are combinational
//   read_data_out    : aligned/extended load data, valid in the DONE cycle
//   stall_out        : freezes upstream while an access is in flight
//   misalign_out     : one-cycle misaligned-access flag
//   bus_err_out      : one-cycle flag for an access aborted on timeout
//   bus              : data-memory req/ack bus (master side)
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] AluResIn,
  input  logic [31:0] write_data_in,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic [1:0]  size_in,
  input  logic        unsigned_in,
  input  logic [4:0]  write_reg_in,
  input  logic [31:0] pc_in,
  input  logic        MemtoRegIn,
  input  logic        DatacIn,
  input  logic        RegwriteIn,
  output logic [4:0]  write_reg_out,
  output logic [31:0] pc_out,
  output logic [31:0] AluResOut,
  output logic        MemtoRegOut,
  output logic        DatacOut,
  output logic        RegwriteOut,
  output logic [31:0] read_data_out,
  output logic        stall_out,
  output logic        misalign_out,
  output logic        bus_err_out,
  mem_access_stage_if.master bus
);

  state_t state, next_state;

  logic             mem_we_q;
  logic [31:0]      mem_addr_q;
  logic [3:0]       mem_be_q;
  logic [31:0]      mem_wdata_q;
  logic [31:0]      rdata_q;
  logic [CNT_W-1:0] cnt;
  logic             err_q;

  logic        mem_op;
  logic        launch;
  logic        stall;
  logic        misalign;
  logic        bus_err;
  logic        timeout_hit;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        al_misaligned;

  mem_align u_align (
    .addr_lo     (AluResIn[1:0]),
    .size        (size_in),
    .is_unsigned (unsigned_in),
    .wd          (write_data_in),
    .rdata       (bus.mem_rdata),
    .be          (al_be),
    .wdata       (al_wdata),
    .load_data   (al_load),
    .misaligned  (al_misaligned)
  );

  assign mem_op      = valid_in & (MemReadIn | MemWriteIn);
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    launch     = 1'b0;
    stall      = 1'b0;
    misalign   = 1'b0;
    bus_err    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          if (al_misaligned) begin
            misalign = 1'b1;
          end else begin
            stall      = 1'b1;
            launch     = 1'b1;
            next_state = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus.mem_ack || timeout_hit) next_state = DONE;
      end
      DONE: begin
        bus_err    = err_q;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      cnt         <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            mem_addr_q  <= {AluResIn[31:2], 2'b00};
            mem_we_q    <= MemWriteIn;
            mem_be_q    <= al_be;
            mem_wdata_q <= al_wdata;
            cnt         <= '0;
            err_q       <= 1'b0;
          end
        end
        REQ: begin
          // Upstream is frozen during REQ, so size/unsigned/addr inputs
          // still describe this access when the ack arrives.
          if (bus.mem_ack) begin
            rdata_q <= mem_we_q ? '0 : al_load;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE:    err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.mem_req   = (state == REQ);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign write_reg_out = write_reg_in;
  assign pc_out        = pc_in;
  assign AluResOut     = AluResIn;
  assign MemtoRegOut   = MemtoRegIn;
  assign DatacOut      = DatacIn;

  // Combinational flags are masked by rst so they read 0 while reset is
  // asserted, independent of whatever sits on the inputs.
  assign stall_out     = rst & stall;
  assign misalign_out  = rst & misalign;
  assign bus_err_out   = rst & bus_err;
  assign RegwriteOut   = rst & RegwriteIn & ~misalign & ~bus_err;
  assign read_data_out = (state == DONE) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  import mips_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        valid_in, MemReadIn, MemWriteIn, unsigned_in;
  logic [31:0] AluResIn, write_data_in, pc_in;
  logic [1:0]  size_in;
  logic [4:0]  write_reg_in;
  logic        MemtoRegIn, DatacIn, RegwriteIn;
  logic [4:0]  write_reg_out;
  logic [31:0] pc_out, AluResOut, read_data_out;
  logic        MemtoRegOut, DatacOut, RegwriteOut;
  logic        stall_out, misalign_out, bus_err_out;

  int checks = 0;
  int errors = 0;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .AluResIn(AluResIn),
    .write_data_in(write_data_in), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
    .size_in(size_in), .unsigned_in(unsigned_in), .write_reg_in(write_reg_in),
    .pc_in(pc_in), .MemtoRegIn(MemtoRegIn), .DatacIn(DatacIn), .RegwriteIn(RegwriteIn),
    .write_reg_out(write_reg_out), .pc_out(pc_out), .AluResOut(AluResOut),
    .MemtoRegOut(MemtoRegOut), .DatacOut(DatacOut), .RegwriteOut(RegwriteOut),
    .read_data_out(read_data_out), .stall_out(stall_out), .misalign_out(misalign_out),
    .bus_err_out(bus_err_out), .bus(bus)
  );

  task automatic set_op(input logic [31:0] addr, input logic [31:0] wd, input logic rd,
                        input logic wr, input logic [1:0] sz, input logic uns);
    valid_in = 1'b1; AluResIn = addr; write_data_in = wd; MemReadIn = rd; MemWriteIn = wr;
    size_in = sz; unsigned_in = uns; RegwriteIn = rd; MemtoRegIn = rd; DatacIn = 1'b0;
    write_reg_in = 5'd7; pc_in = 32'h0040_0000 | addr;
  endtask

  task automatic clear_op();
    valid_in = 1'b0; MemReadIn = 1'b0; MemWriteIn = 1'b0; RegwriteIn = 1'b0;
    MemtoRegIn = 1'b0; DatacIn = 1'b0; AluResIn = '0; write_data_in = '0;
    size_in = SZ_WORD; unsigned_in = 1'b0; write_reg_in = '0; pc_in = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; clear_op(); bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    set_op(32'h10, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0);
    #1;
    if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b want 0", bus.mem_req); end checks++;
    if (stall_out !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", stall_out); end checks++;
    if (RegwriteOut !== 1'b0) begin errors++; $display("FAIL rst_regwrite got %0b want 0", RegwriteOut); end checks++;
    if ({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== 69'h0) begin
      errors++; $display("FAIL rst_bus got we=%0b be=%h addr=%h wd=%h want 0", bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
    end checks++;
    if ({read_data_out, misalign_out, bus_err_out} !== 34'h0) begin
      errors++; $display("FAIL rst_flags got rd=%h mis=%0b err=%0b want 0", read_data_out, misalign_out, bus_err_out);
    end checks++;
    clear_op();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    clear_op(); write_reg_in = 5'd9; pc_in = 32'h0040_1234; AluResIn = 32'h1234_5679;
    MemtoRegIn = 1'b1; DatacIn = 1'b1; RegwriteIn = 1'b1;
    #1;
    if ({write_reg_out, pc_out, AluResOut, MemtoRegOut, DatacOut, RegwriteOut} !== {5'd9, 32'h0040_1234, 32'h1234_5679, 3'b111}) begin
      errors++; $display("FAIL passthru got wr=%0d pc=%h alu=%h m=%0b d=%0b r=%0b", write_reg_out, pc_out, AluResOut, MemtoRegOut, DatacOut, RegwriteOut);
    end checks++;
    if ({stall_out, read_data_out, bus.mem_req} !== 34'h0) begin
      errors++; $display("FAIL idle_noop got stall=%0b rd=%h req=%0b want 0", stall_out, read_data_out, bus.mem_req);
    end checks++;
  endtask

  task automatic test_word_load();
    int stalls, reqs;
    stalls = 0; reqs = 0;
    @(negedge clk); set_op(32'h10, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0); #1;
    stalls += int'(stall_out); reqs += int'(bus.mem_req);
    @(negedge clk); bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF; #1;
    stalls += int'(stall_out); reqs += int'(bus.mem_req);
    if ({bus.mem_addr, bus.mem_be, bus.mem_we} !== {32'h10, 4'hF, 1'b0}) begin
      errors++; $display("FAIL wl_bus got addr=%h be=%b we=%0b want 10 1111 0", bus.mem_addr, bus.mem_be, bus.mem_we);
    end checks++;
    @(negedge clk); bus.mem_ack = 1'b0; bus.mem_rdata = '0; #1;
    stalls += int'(stall_out); reqs += int'(bus.mem_req);
    if (read_data_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wl_data got %h want deadbeef", read_data_out); end checks++;
    if (RegwriteOut !== 1'b1) begin errors++; $display("FAIL wl_regwrite got %0b want 1", RegwriteOut); end checks++;
    if (stalls != 2) begin errors++; $display("FAIL wl_stall_cycles got %0d want 2", stalls); end checks++;
    if (reqs != 1) begin errors++; $display("FAIL wl_req_cycles got %0d want 1", reqs); end checks++;
    @(negedge clk); clear_op();
  endtask

  task automatic test_byte_load(input logic uns, input logic [31:0] exp);
    @(negedge clk); set_op(32'h103, 32'h0, 1'b1, 1'b0, SZ_BYTE, uns);
    @(negedge clk); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h8012_3456; #1;
    if (bus.mem_be !== 4'b1000) begin errors++; $display("FAIL bl_be uns=%0b got %b want 1000", uns, bus.mem_be); end checks++;
    @(negedge clk); bus.mem_ack = 1'b0; bus.mem_rdata = '0; #1;
    if (read_data_out !== exp) begin errors++; $display("FAIL bl_data uns=%0b got %h want %h", uns, read_data_out, exp); end checks++;
    @(negedge clk); clear_op();
  endtask

  task automatic test_half_store();
    @(negedge clk); set_op(32'h202, 32'h0000_ABCD, 1'b0, 1'b1, SZ_HALF, 1'b0); #1;
    if ({stall_out, bus.mem_req} !== 2'b10) begin errors++; $display("FAIL hs_idle got stall=%0b req=%0b want 1 0", stall_out, bus.mem_req); end checks++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bus.mem_ack = (i == 3); #1;
      if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr} !== {2'b11, 4'b1100, 32'hABCD_ABCD, 32'h200}) begin
        errors++; $display("FAIL hs_hold%0d got req=%0b we=%0b be=%b wd=%h addr=%h", i, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr);
      end checks++;
    end
    @(negedge clk); bus.mem_ack = 1'b0; #1;
    if ({stall_out, bus.mem_req, read_data_out} !== 34'h0) begin
      errors++; $display("FAIL hs_done got stall=%0b req=%0b rd=%h want 0", stall_out, bus.mem_req, read_data_out);
    end checks++;
    @(negedge clk); clear_op();
  endtask

  task automatic test_misalign();
    @(negedge clk); set_op(32'h301, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0); #1;
    if ({misalign_out, stall_out, bus.mem_req, RegwriteOut} !== 4'b1000) begin
      errors++; $display("FAIL mis_word got mis=%0b stall=%0b req=%0b rw=%0b want 1 0 0 0", misalign_out, stall_out, bus.mem_req, RegwriteOut);
    end checks++;
    @(negedge clk); set_op(32'h305, 32'h0, 1'b1, 1'b0, SZ_HALF, 1'b0); #1;
    if ({misalign_out, bus.mem_req, RegwriteOut} !== 3'b100) begin
      errors++; $display("FAIL mis_half got mis=%0b req=%0b rw=%0b want 1 0 0", misalign_out, bus.mem_req, RegwriteOut);
    end checks++;
    @(negedge clk); clear_op(); #1;
    if ({misalign_out, bus.mem_req, stall_out} !== 3'b000) begin
      errors++; $display("FAIL mis_after got mis=%0b req=%0b stall=%0b want 0", misalign_out, bus.mem_req, stall_out);
    end checks++;
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    @(negedge clk); set_op(32'h400, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk); #1;
      if (bus.mem_req) n++;
      else break;
    end
    if (n != 16) begin errors++; $display("FAIL to_req_cycles got %0d want 16", n); end checks++;
    if ({bus_err_out, read_data_out, RegwriteOut, stall_out} !== {1'b1, 32'h0, 2'b00}) begin
      errors++; $display("FAIL to_done got err=%0b rd=%h rw=%0b stall=%0b want 1 0 0 0", bus_err_out, read_data_out, RegwriteOut, stall_out);
    end checks++;
    @(negedge clk); clear_op(); #1;
    if ({bus_err_out, bus.mem_req, stall_out} !== 3'b000) begin
      errors++; $display("FAIL to_idle got err=%0b req=%0b stall=%0b want 0", bus_err_out, bus.mem_req, stall_out);
    end checks++;
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk); set_op(32'h500, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0);
    @(negedge clk);
    @(negedge clk); #1;
    if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL mr_pre got req=%0b want 1", bus.mem_req); end checks++;
    rst = 1'b0; #1;
    if ({bus.mem_req, stall_out} !== 2'b00) begin
      errors++; $display("FAIL mr_async got req=%0b stall=%0b want 0 0", bus.mem_req, stall_out);
    end checks++;
    @(negedge clk); clear_op(); rst = 1'b1;
    @(negedge clk); #1;
    if ({bus.mem_req, stall_out, read_data_out} !== 34'h0) begin
      errors++; $display("FAIL mr_after got req=%0b stall=%0b rd=%h want 0", bus.mem_req, stall_out, read_data_out);
    end checks++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk); set_op(32'h600, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0);
    @(negedge clk); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_1111;
    @(negedge clk); bus.mem_ack = 1'b0; bus.mem_rdata = '0; #1;
    if ({read_data_out, bus.mem_req} !== {32'h1111_1111, 1'b0}) begin
      errors++; $display("FAIL bb_done_a got rd=%h req=%0b want 11111111 0", read_data_out, bus.mem_req);
    end checks++;
    // second op arrives; a stray ack in IDLE must be ignored
    @(negedge clk); set_op(32'h604, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0BAD; #1;
    if ({bus.mem_req, stall_out} !== 2'b01) begin
      errors++; $display("FAIL bb_idle_b got req=%0b stall=%0b want 0 1", bus.mem_req, stall_out);
    end checks++;
    @(negedge clk); bus.mem_ack = 1'b0; bus.mem_rdata = '0; #1;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h604}) begin
      errors++; $display("FAIL bb_req_b got req=%0b addr=%h want 1 604", bus.mem_req, bus.mem_addr);
    end checks++;
    @(negedge clk); bus.mem_ack = 1'b1; bus.mem_rdata = 32'h2222_2222; #1;
    if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL bb_wait_b got req=%0b want 1", bus.mem_req); end checks++;
    @(negedge clk); bus.mem_ack = 1'b0; bus.mem_rdata = '0; #1;
    if ({read_data_out, stall_out} !== {32'h2222_2222, 1'b0}) begin
      errors++; $display("FAIL bb_done_b got rd=%h stall=%0b want 22222222 0", read_data_out, stall_out);
    end checks++;
    @(negedge clk); clear_op();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_word_load();
    test_byte_load(1'b0, 32'hFFFF_FF80);
    test_byte_load(1'b1, 32'h0000_0080);
    test_half_store();
    test_misalign();
    test_timeout();
    test_reset_mid_req();
    test_back_to_back();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
